fprecsqrt_arbiter: RTL

Shares one fixed-latency, fully pipelined fprecsqrt unit (1/sqrt(x), IEEE-754 single) between N_REQ requesters. Each requester has a valid/ready input handshake, and the unit has no handshake of its own. The arbiter grants one requester per cycle in round-robin order and drives the unit's operand. It tracks the requester ID of every in-flight operation in a tag pipeline and steers each result back to its requester with a valid strobe. The block sits between the requesting datapaths and the fprecsqrt instance, which is instantiated outside.

---
 rtl/fprecsqrt_pkg.sv | 22 ++
 rtl/fprecsqrt_arbiter_rr_arbiter.sv | 29 ++
 rtl/fprecsqrt_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fprecsqrt_pkg.sv
// ============================================================================
// fprecsqrt_pkg : shared constants and tag type for the fprecsqrt arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package fprecsqrt_pkg;

  localparam int          WIDTH_DEFAULT = 32;
  localparam logic [31:0] FP_ONE        = 32'h3F800000;

  // Holds the requester ID for any N_REQ up to 2**TAG_ID_W.
  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/fprecsqrt_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin grant, first request at/after ptr_i
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o
);

  logic [N_REQ-1:0] w_rot_req;
  logic [N_REQ-1:0] w_rot_gnt;

  // Rotate so the pointer position becomes bit 0, pick the lowest set bit,
  // then rotate the one-hot result back into requester order.
  always_comb begin
    w_rot_req = N_REQ'({req_i, req_i} >> ptr_i);
    w_rot_gnt = w_rot_req & (~w_rot_req + N_REQ'(1));
    grant_o   = N_REQ'(({w_rot_gnt, w_rot_gnt} << ptr_i) >> N_REQ);
  end

endmodule

`default_nettype wire

// File: rtl/fprecsqrt_arbiter.sv
// ============================================================================
// fprecsqrt_arbiter : round-robin sharing of one pipelined fprecsqrt unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module fprecsqrt_arbiter
  import fprecsqrt_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int LATENCY = 8,
  parameter  int WIDTH   = WIDTH_DEFAULT,
  localparam int PTR_W   = $clog2(N_REQ),
  localparam int IFW     = $clog2(LATENCY + 2)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_value,
  output logic [WIDTH-1:0]       fp_value,
  input  logic [WIDTH-1:0]       fp_result,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_result,
  output logic [IFW-1:0]         in_flight,
  output logic                   idle
);

  localparam logic [IFW-1:0] IF_MAX = IFW'(LATENCY + 1);

  generate
    if (N_REQ < 2 || N_REQ > (1 << TAG_ID_W)) begin : g_bad_nreq
      $error("fprecsqrt_arbiter: N_REQ out of range");
    end
    if (LATENCY < 2) begin : g_bad_latency
      $error("fprecsqrt_arbiter: LATENCY must be at least 2");
    end
  endgenerate

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] fp_value_q, fp_value_d;
  tag_t             tag_q [LATENCY];
  tag_t             tag_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [IFW-1:0]   in_flight_q, in_flight_d;

  logic [N_REQ-1:0] w_grant_raw;
  logic [N_REQ-1:0] w_grant;
  logic             w_accept;
  logic [PTR_W-1:0] w_acc_id;
  logic             w_rsp_any;
  tag_t             w_tag_last;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (w_grant_raw)
  );

  // No grants are handed out while the block is held in reset.
  assign w_grant  = w_grant_raw & {N_REQ{aresetn}};
  assign w_accept = |w_grant;

  always_comb begin
    w_acc_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_acc_id = PTR_W'(i);
      end
    end
  end

  assign w_tag_last = tag_q[LATENCY-1];
  assign w_rsp_any  = |rsp_valid_q;

  always_comb begin
    ptr_d = ptr_q;
    if (w_accept) begin
      ptr_d = (w_acc_id == PTR_W'(N_REQ - 1)) ? '0 : w_acc_id + PTR_W'(1);
    end
  end

  always_comb begin
    fp_value_d = '0;
    tag_d      = '0;
    if (w_accept) begin
      fp_value_d = req_value[w_acc_id*WIDTH +: WIDTH];
      tag_d.vld  = 1'b1;
      tag_d.id   = TAG_ID_W'(w_acc_id);
    end
  end

  always_comb begin
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    if (w_tag_last.vld) begin
      rsp_result_d = fp_result;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_valid_d[i] = (w_tag_last.id == TAG_ID_W'(i));
      end
    end
  end

  // Accept and response in the same cycle cancel; saturate at both ends.
  always_comb begin
    in_flight_d = in_flight_q;
    if (w_accept && !w_rsp_any) begin
      if (in_flight_q != IF_MAX) begin
        in_flight_d = in_flight_q + IFW'(1);
      end
    end else if (!w_accept && w_rsp_any) begin
      if (in_flight_q != '0) begin
        in_flight_d = in_flight_q - IFW'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q        <= '0;
      fp_value_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      in_flight_q  <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q        <= ptr_d;
      fp_value_q   <= fp_value_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      in_flight_q  <= in_flight_d;
      tag_q[0]     <= tag_d;
      for (int s = 1; s < LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign req_ready  = w_grant;
  assign fp_value   = fp_value_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign in_flight  = in_flight_q;
  assign idle       = (in_flight_q == '0) && (req_valid == '0);

endmodule

`default_nettype wire
